// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
package mc_ctrl_pkg;

   localparam int unsigned OP_W    = 6;
   localparam int unsigned FAULT_W = 2;
   localparam int unsigned SEL_W   = 2;

   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      MEMADR,
      MEMRD,
      MEMWB,
      MEMWR,
      EXEC,
      RWB,
      BRANCH,
      ADDIEX,
      ADDIWB,
      JUMP,
      LUIWB,
      TRAP
   } state_e;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;
   localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;

   localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b00;
   localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
   localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b10;
   localparam logic [SEL_W-1:0] ALUOP_NONE  = 2'b11;

   localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
   localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [SEL_W-1:0] SRCB_B       = 2'b00;
   localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
   localparam logic [SEL_W-1:0] SRCB_IMM     = 2'b10;
   localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [FAULT_W-1:0] FAULT_NONE    = 2'b00;
   localparam logic [FAULT_W-1:0] FAULT_ILLEGAL = 2'b01;
   localparam logic [FAULT_W-1:0] FAULT_TIMEOUT = 2'b10;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive un-ready memory wait cycles; expired flags the last allowed one.
module mem_wait_timer #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic count_en,
   input  logic clear,
   output logic expired
);

   localparam int unsigned CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   assign expired = (count_q == LAST);

   // Next count: clear wins, and the count parks at LAST so it never wraps.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (count_en && !expired) begin
         count_d = count_q + CW'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM with memory handshake, fault trap and retire counter.
module multicycle_control
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [OP_W-1:0]      opcode,
   input  logic                 mem_ready,
   output logic                 IorD,
   output logic                 MemRead,
   output logic                 MemWrite,
   output logic                 IRWrite,
   output logic                 PCWrite,
   output logic                 PCWriteCond,
   output logic                 BNE,
   output logic [SEL_W-1:0]     PCSrc,
   output logic                 ALUSrcA,
   output logic [SEL_W-1:0]     ALUSrcB,
   output logic [SEL_W-1:0]     ALUOp,
   output logic                 RegDst,
   output logic                 MemtoReg,
   output logic                 RegWrite,
   output logic                 LUI,
   output logic [FAULT_W-1:0]   fault,
   output logic [CNT_W-1:0]     retired
);

   state_e             state_q;
   state_e             state_d;
   logic [FAULT_W-1:0] fault_q;
   logic [FAULT_W-1:0] fault_d;
   logic [CNT_W-1:0]   retired_q;
   logic [CNT_W-1:0]   retired_d;
   // lw/sw choice is captured in DECODE so MEMADR never looks at opcode.
   logic               is_store_q;
   logic               is_store_d;
   logic               retire;
   logic               wait_en;
   logic               wait_clr;
   logic               wait_expired;

   assign wait_clr = mem_ready | (state_d != state_q);
   assign fault    = reset ? FAULT_NONE : fault_q;
   assign retired  = reset ? '0 : retired_q;

   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_wait_timer (
      .clk      (clk),
      .reset    (reset),
      .count_en (wait_en),
      .clear    (wait_clr),
      .expired  (wait_expired)
   );

   // State, fault, store flag and retire counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= FETCH;
         fault_q    <= FAULT_NONE;
         retired_q  <= '0;
         is_store_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         fault_q    <= fault_d;
         retired_q  <= retired_d;
         is_store_q <= is_store_d;
      end
   end

   // Next state and state-decoded controls; everything is forced low while reset is high.
   always_comb begin
      state_d     = state_q;
      fault_d     = fault_q;
      is_store_d  = is_store_q;
      retire      = 1'b0;
      wait_en     = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      BNE         = 1'b0;
      PCSrc       = PCSRC_ALU;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_B;
      ALUOp       = ALUOP_FUNCT;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      LUI         = 1'b0;

      if (!reset) begin
         unique case (state_q)
            FETCH: begin
               MemRead = 1'b1;
               ALUSrcB = SRCB_FOUR;
               ALUOp   = ALUOP_ADD;
               wait_en = !mem_ready;
               if (mem_ready) begin
                  IRWrite = 1'b1;
                  PCWrite = 1'b1;
                  state_d = DECODE;
               end else if (wait_expired) begin
                  state_d = TRAP;
                  fault_d = FAULT_TIMEOUT;
               end
            end
            DECODE: begin
               ALUSrcB = SRCB_IMM_SH2;
               ALUOp   = ALUOP_ADD;
               unique case (opcode)
                  OP_RTYPE:       state_d = EXEC;
                  OP_LW, OP_SW: begin
                     state_d    = MEMADR;
                     is_store_d = (opcode == OP_SW);
                  end
                  OP_BEQ, OP_BNE: state_d = BRANCH;
                  OP_ADDI:        state_d = ADDIEX;
                  OP_J:           state_d = JUMP;
                  OP_LUI:         state_d = LUIWB;
                  default: begin
                     state_d = TRAP;
                     fault_d = FAULT_ILLEGAL;
                  end
               endcase
            end
            MEMADR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = SRCB_IMM;
               ALUOp   = ALUOP_ADD;
               state_d = is_store_q ? MEMWR : MEMRD;
            end
            MEMRD: begin
               IorD    = 1'b1;
               MemRead = 1'b1;
               wait_en = !mem_ready;
               if (mem_ready) begin
                  state_d = MEMWB;
               end else if (wait_expired) begin
                  state_d = TRAP;
                  fault_d = FAULT_TIMEOUT;
               end
            end
            MEMWB: begin
               MemtoReg = 1'b1;
               RegWrite = 1'b1;
               retire   = 1'b1;
               state_d  = FETCH;
            end
            MEMWR: begin
               IorD     = 1'b1;
               MemWrite = 1'b1;
               wait_en  = !mem_ready;
               if (mem_ready) begin
                  retire  = 1'b1;
                  state_d = FETCH;
               end else if (wait_expired) begin
                  state_d = TRAP;
                  fault_d = FAULT_TIMEOUT;
               end
            end
            EXEC: begin
               ALUSrcA = 1'b1;
               ALUOp   = ALUOP_FUNCT;
               state_d = RWB;
            end
            RWB: begin
               RegDst   = 1'b1;
               RegWrite = 1'b1;
               retire   = 1'b1;
               state_d  = FETCH;
            end
            BRANCH: begin
               ALUSrcA     = 1'b1;
               ALUOp       = ALUOP_SUB;
               PCWriteCond = 1'b1;
               PCSrc       = PCSRC_ALUOUT;
               BNE         = (opcode == OP_BNE);
               retire      = 1'b1;
               state_d     = FETCH;
            end
            ADDIEX: begin
               ALUSrcA = 1'b1;
               ALUSrcB = SRCB_IMM;
               ALUOp   = ALUOP_ADD;
               state_d = ADDIWB;
            end
            ADDIWB: begin
               RegWrite = 1'b1;
               retire   = 1'b1;
               state_d  = FETCH;
            end
            JUMP: begin
               PCWrite = 1'b1;
               PCSrc   = PCSRC_JUMP;
               ALUOp   = ALUOP_NONE;
               retire  = 1'b1;
               state_d = FETCH;
            end
            LUIWB: begin
               LUI      = 1'b1;
               ALUSrcB  = SRCB_IMM;
               RegWrite = 1'b1;
               retire   = 1'b1;
               state_d  = FETCH;
            end
            TRAP: begin
               state_d = TRAP;
            end
            default: begin
               state_d = FETCH;
            end
         endcase
      end

      retired_d = retire ? (retired_q + CNT_W'(1)) : retired_q;
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: instruction-plan reference model, directed and random stimulus.
module tb_multicycle_control;

   localparam int T_OUT = 4;
   localparam int CW    = 3;

   localparam logic [5:0] C_R    = 6'b000000;
   localparam logic [5:0] C_LW   = 6'b100011;
   localparam logic [5:0] C_SW   = 6'b101011;
   localparam logic [5:0] C_BEQ  = 6'b000100;
   localparam logic [5:0] C_BNE  = 6'b000101;
   localparam logic [5:0] C_ADDI = 6'b001000;
   localparam logic [5:0] C_J    = 6'b000010;
   localparam logic [5:0] C_LUI  = 6'b001111;
   localparam logic [5:0] C_BAD  = 6'b111111;

   // Instruction phases used by the reference model.
   localparam int P_FETCH  = 0;
   localparam int P_DECODE = 1;
   localparam int P_MEMADR = 2;
   localparam int P_MEMRD  = 3;
   localparam int P_MEMWB  = 4;
   localparam int P_MEMWR  = 5;
   localparam int P_EXEC   = 6;
   localparam int P_RWB    = 7;
   localparam int P_BRANCH = 8;
   localparam int P_ADDIEX = 9;
   localparam int P_ADDIWB = 10;
   localparam int P_JUMP   = 11;
   localparam int P_LUIWB  = 12;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [5:0]    opcode = '0;
   logic          mem_ready = 1'b0;
   logic          IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, BNE;
   logic [1:0]    PCSrc, ALUSrcB, ALUOp;
   logic          ALUSrcA, RegDst, MemtoReg, RegWrite, LUI;
   logic [1:0]    fault;
   logic [CW-1:0] retired;

   multicycle_control #(
      .MEM_TIMEOUT (T_OUT),
      .CNT_W       (CW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .opcode      (opcode),
      .mem_ready   (mem_ready),
      .IorD        (IorD),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .IRWrite     (IRWrite),
      .PCWrite     (PCWrite),
      .PCWriteCond (PCWriteCond),
      .BNE         (BNE),
      .PCSrc       (PCSrc),
      .ALUSrcA     (ALUSrcA),
      .ALUSrcB     (ALUSrcB),
      .ALUOp       (ALUOp),
      .RegDst      (RegDst),
      .MemtoReg    (MemtoReg),
      .RegWrite    (RegWrite),
      .LUI         (LUI),
      .fault       (fault),
      .retired     (retired)
   );

   always #5 clk = ~clk;

   logic [17:0] dut_ctrl;
   assign dut_ctrl = {IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, BNE, PCSrc,
                      ALUSrcA, ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite, LUI};

   int passed = 0;
   int total  = 0;

   // Reference model state: current phase, remaining phases of the instruction, trap info.
   int   m_phase   = P_FETCH;
   int   m_plan[$];
   bit   m_trap    = 1'b0;
   int   m_fault   = 0;
   int   m_retired = 0;
   int   m_wait    = 0;

   // Samples of the last checked cycle, for the hand-computed expectations.
   logic [17:0] s_ctrl;
   logic [1:0]  s_fault;
   logic [CW-1:0] s_ret;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
   endtask

   // Control word the spec demands for a phase.
   function automatic logic [17:0] exp_ctrl(input int ph, input logic rdy, input logic [5:0] op);
      logic iord, mr, mw, irw, pcw, pcwc, bne, srca, rdst, m2r, rw, lui;
      logic [1:0] pcs, srcb, aop;
      {iord, mr, mw, irw, pcw, pcwc, bne, srca, rdst, m2r, rw, lui} = '0;
      pcs = 2'b00; srcb = 2'b00; aop = 2'b00;
      case (ph)
         P_FETCH:  begin mr = 1; srcb = 2'b01; aop = 2'b10; irw = rdy; pcw = rdy; end
         P_DECODE: begin srcb = 2'b11; aop = 2'b10; end
         P_MEMADR: begin srca = 1; srcb = 2'b10; aop = 2'b10; end
         P_MEMRD:  begin iord = 1; mr = 1; end
         P_MEMWB:  begin m2r = 1; rw = 1; end
         P_MEMWR:  begin iord = 1; mw = 1; end
         P_EXEC:   begin srca = 1; aop = 2'b00; end
         P_RWB:    begin rdst = 1; rw = 1; end
         P_BRANCH: begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; bne = (op == C_BNE); end
         P_ADDIEX: begin srca = 1; srcb = 2'b10; aop = 2'b10; end
         P_ADDIWB: begin rw = 1; end
         P_JUMP:   begin pcw = 1; pcs = 2'b10; aop = 2'b11; end
         P_LUIWB:  begin lui = 1; srcb = 2'b10; rw = 1; end
         default:  ;
      endcase
      return {iord, mr, mw, irw, pcw, pcwc, bne, pcs, srca, srcb, aop, rdst, m2r, rw, lui};
   endfunction

   // Move to the next phase of the plan, or retire and fetch again.
   task automatic next_phase();
      m_wait = 0;
      if (m_phase == P_FETCH) m_phase = P_DECODE;
      else if (m_plan.size() > 0) m_phase = m_plan.pop_front();
      else begin
         m_retired = (m_retired + 1) % (1 << CW);
         m_phase   = P_FETCH;
      end
   endtask

   task automatic model_step(input logic r, input logic [5:0] op, input logic rdy);
      if (r) begin
         m_phase = P_FETCH; m_plan.delete(); m_trap = 0; m_fault = 0; m_retired = 0; m_wait = 0;
      end else if (!m_trap) begin
         if (m_phase == P_FETCH || m_phase == P_MEMRD || m_phase == P_MEMWR) begin
            if (rdy) next_phase();
            else if (m_wait == T_OUT - 1) begin m_trap = 1; m_fault = 2; end
            else m_wait++;
         end else if (m_phase == P_DECODE) begin
            m_plan.delete();
            case (op)
               C_R:           m_plan = '{P_EXEC, P_RWB};
               C_LW:          m_plan = '{P_MEMADR, P_MEMRD, P_MEMWB};
               C_SW:          m_plan = '{P_MEMADR, P_MEMWR};
               C_BEQ, C_BNE:  m_plan = '{P_BRANCH};
               C_ADDI:        m_plan = '{P_ADDIEX, P_ADDIWB};
               C_J:           m_plan = '{P_JUMP};
               C_LUI:         m_plan = '{P_LUIWB};
               default: begin m_trap = 1; m_fault = 1; end
            endcase
            if (!m_trap) next_phase();
         end else begin
            next_phase();
         end
      end
   endtask

   // One clock: drive on the falling edge, check mid-low-phase, then advance the model.
   task automatic cyc(input logic r, input logic [5:0] op, input logic rdy);
      logic [17:0] e_ctrl;
      int e_fault, e_ret;
      @(negedge clk);
      reset = r; opcode = op; mem_ready = rdy;
      #1;
      e_ctrl  = (r || m_trap) ? 18'd0 : exp_ctrl(m_phase, rdy, op);
      e_fault = r ? 0 : m_fault;
      e_ret   = r ? 0 : m_retired;
      s_ctrl = dut_ctrl; s_fault = fault; s_ret = retired;
      chk("ctrl",    32'(dut_ctrl), 32'(e_ctrl));
      chk("fault",   32'(fault),    32'(e_fault));
      chk("retired", 32'(retired),  32'(e_ret));
      @(posedge clk);
      model_step(r, op, rdy);
   endtask

   function automatic logic [5:0] pick_op();
      logic [5:0] legal [8];
      legal = '{C_R, C_LW, C_SW, C_BEQ, C_BNE, C_ADDI, C_J, C_LUI};
      if ($urandom_range(0, 15) == 0) return 6'($urandom_range(0, 63));
      return legal[$urandom_range(0, 7)];
   endfunction

   // Bit positions inside the control word.
   localparam int B_IORD = 17, B_MR = 16, B_IRW = 14, B_PCWC = 12, B_BNE = 11;
   localparam int B_RDST = 3, B_M2R = 2, B_RW = 1;

   initial begin
      logic [5:0] cur_op;
      logic r, rdy;
      int trap_cnt;

      // Reset state.
      cyc(1, C_R, 0);
      chk("reset_ctrl_zero", 32'(s_ctrl), 32'd0);
      chk("reset_retired_zero", 32'(s_ret), 32'd0);

      // R-type at zero wait: four cycles, write-back in the fourth.
      for (int i = 1; i <= 4; i++) cyc(0, C_R, 1);
      chk("rtype_regwrite", 32'(s_ctrl[B_RW]), 32'd1);
      chk("rtype_regdst",   32'(s_ctrl[B_RDST]), 32'd1);
      cyc(0, C_R, 0);
      chk("rtype_retired", 32'(s_ret), 32'd1);

      // lw with three wait cycles in MEMRD: eight cycles.
      cyc(1, C_LW, 0);
      for (int i = 1; i <= 8; i++) begin
         cyc(0, C_LW, (i >= 4 && i <= 6) ? 1'b0 : 1'b1);
         if (i >= 4 && i <= 7) chk("lw_iord_memrd", 32'(s_ctrl[B_IORD]), 32'd1);
         if (i == 7) chk("lw_no_early_wb", 32'(s_ctrl[B_M2R]), 32'd0);
      end
      chk("lw_memtoreg_last", 32'(s_ctrl[B_M2R]), 32'd1);

      // bne then beq branch cycle.
      cyc(1, C_BNE, 0);
      for (int i = 1; i <= 3; i++) cyc(0, C_BNE, 1);
      chk("bne_pcwritecond", 32'(s_ctrl[B_PCWC]), 32'd1);
      chk("bne_flag", 32'(s_ctrl[B_BNE]), 32'd1);
      chk("bne_pcsrc", 32'(s_ctrl[10:9]), 32'd1);
      cyc(1, C_BEQ, 0);
      for (int i = 1; i <= 3; i++) cyc(0, C_BEQ, 1);
      chk("beq_flag", 32'(s_ctrl[B_BNE]), 32'd0);

      // Illegal opcode traps and sticks until reset.
      cyc(1, C_BAD, 0);
      cyc(0, C_BAD, 1);
      cyc(0, C_BAD, 1);
      for (int i = 0; i < 20; i++) cyc(0, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
      chk("illegal_fault", 32'(s_fault), 32'd1);
      chk("illegal_ctrl_zero", 32'(s_ctrl), 32'd0);
      cyc(1, C_R, 0);
      cyc(0, C_R, 0);
      chk("illegal_cleared", 32'(s_fault), 32'd0);
      chk("refetch_memread", 32'(s_ctrl[B_MR]), 32'd1);

      // Fetch timeout after exactly four un-ready cycles.
      cyc(1, C_J, 0);
      for (int i = 0; i < 4; i++) cyc(0, C_J, 0);
      chk("timeout_still_fetch", 32'(s_ctrl[B_MR]), 32'd1);
      cyc(0, C_J, 0);
      chk("timeout_fault", 32'(s_fault), 32'd2);
      // Ready on the fourth cycle wins over the timeout.
      cyc(1, C_J, 0);
      for (int i = 0; i < 3; i++) cyc(0, C_J, 0);
      cyc(0, C_J, 1);
      chk("ready_wins_irwrite", 32'(s_ctrl[B_IRW]), 32'd1);
      cyc(0, C_J, 1);
      chk("ready_wins_nofault", 32'(s_fault), 32'd0);
      chk("ready_wins_decode", 32'(s_ctrl[7:6]), 32'd3);

      // Nine jumps wrap the 3-bit counter to 1; reset in the tenth DECODE clears it.
      cyc(1, C_J, 0);
      for (int i = 0; i < 27; i++) cyc(0, C_J, 1);
      cyc(0, C_J, 1);
      chk("wrap_retired", 32'(s_ret), 32'd1);
      cyc(1, C_J, 1);
      chk("abort_ctrl_zero", 32'(s_ctrl), 32'd0);
      cyc(0, C_J, 1);
      chk("abort_retired", 32'(s_ret), 32'd0);

      // Random traffic against the model.
      cur_op = C_R;
      trap_cnt = 0;
      for (int i = 0; i < 3000; i++) begin
         if (!m_trap && m_phase == P_FETCH) cur_op = pick_op();
         rdy = ($urandom_range(0, 9) < 7);
         r = 1'b0;
         if (m_trap) begin
            trap_cnt++;
            if (trap_cnt > int'($urandom_range(1, 10))) begin r = 1'b1; trap_cnt = 0; end
         end else if ($urandom_range(0, 63) == 0) begin
            r = 1'b1;
         end
         cyc(r, cur_op, rdy);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
